// File: rtl/muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_unit_pkg
// Shared definitions for the multiply/divide unit:
//   - one-hot op codes emitted by the R-type ALU control decoder
//   - FSM state encoding
//   - is_legal_mc(): true only for exactly one recognised op bit
// -----------------------------------------------------------------------------
package muldiv_unit_pkg;

  localparam logic [3:0] MultMc  = 4'b0001;
  localparam logic [3:0] MultuMc = 4'b0010;
  localparam logic [3:0] DivMc   = 4'b0100;
  localparam logic [3:0] DivuMc  = 4'b1000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2
  } state_e;

  function automatic logic is_legal_mc(input logic [3:0] mc);
    return (mc == MultMc) || (mc == MultuMc) || (mc == DivMc) || (mc == DivuMc);
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// -----------------------------------------------------------------------------
// muldiv_div_core
// Unsigned restoring divider datapath, one quotient bit per i_step.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_load        capture dividend/divisor, clear partial remainder
//   i_step        perform one shift/compare/subtract iteration
//   i_dividend    unsigned dividend magnitude
//   i_divisor     unsigned divisor magnitude
//   o_quot        quotient (valid after WIDTH steps)
//   o_rem         remainder (valid after WIDTH steps)
// -----------------------------------------------------------------------------
module muldiv_div_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quot,
  output logic [WIDTH-1:0] o_rem
);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_dvsr;

  logic [WIDTH:0]   w_shift;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;

  // Quotient register doubles as the dividend shifter: its MSB feeds the remainder.
  assign w_shift = {r_rem, r_quot[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dvsr});
  // When w_ge holds the true difference is below the divisor, so WIDTH bits suffice.
  assign w_diff  = w_shift[WIDTH-1:0] - r_dvsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_quot <= '0;
      r_dvsr <= '0;
    end else if (i_load) begin
      r_rem  <= '0;
      r_quot <= i_dividend;
      r_dvsr <= i_divisor;
    end else if (i_step) begin
      r_rem  <= w_ge ? w_diff : w_shift[WIDTH-1:0];
      r_quot <= {r_quot[WIDTH-2:0], w_ge};
    end
  end

  assign o_quot = r_quot;
  assign o_rem  = r_rem;

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Parameters:
//   WIDTH     operand width (HI and LO are WIDTH bits each)
//   FAST_MUL  0: shift-add multiply over WIDTH cycles, 1: single-cycle multiply
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start_valid/ready      start handshake; start_ready == ~busy
//   mul_control            one-hot op: mult, multu, div, divu
//   src_a, src_b           rs / rt operands
//   cancel                 abort in-flight op (RUN/FIX), HI/LO untouched
//   hi_we, lo_we, wdata    mthi / mtlo
//   hi, lo                 architectural HI / LO
//   busy                   op in flight
//   done                   one-cycle pulse after HI/LO take a result
// -----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned FAST_MUL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [3:0]       mul_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] MostNeg = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           r_state;
  state_e           w_state_next;

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_a_raw;
  logic [WIDTH-1:0] r_mag_a;
  logic             r_sa;
  logic             r_sb;
  logic             r_is_mul;
  logic             r_div_zero;
  logic             r_div_ovf;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;

  logic             w_op_mul;
  logic             w_op_signed;
  logic             w_accept;
  logic             w_fix_write;
  logic             w_step_mul;
  logic             w_step_div;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;

  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign w_op_mul    = (mul_control == MultMc) || (mul_control == MultuMc);
  assign w_op_signed = (mul_control == MultMc) || (mul_control == DivMc);
  assign w_accept    = (r_state == StIdle) && start_valid && is_legal_mc(mul_control);
  assign w_mag_a     = (w_op_signed && src_a[WIDTH-1]) ? -src_a : src_a;
  assign w_mag_b     = (w_op_signed && src_b[WIDTH-1]) ? -src_b : src_b;

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_next = ((FAST_MUL != 0) && w_op_mul) ? StFix : StRun;
        end
      end
      StRun: begin
        if (cancel) begin
          w_state_next = StIdle;
        end else if (r_cnt == '0) begin
          w_state_next = StFix;
        end
      end
      StFix:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    busy        = (r_state != StIdle);
    start_ready = (r_state == StIdle);
    w_fix_write = (r_state == StFix) && !cancel;
    w_step_mul  = (r_state == StRun) && r_is_mul;
    w_step_div  = (r_state == StRun) && !r_is_mul;
  end

  // ---------------------------------------------------------------------------
  // Operand capture and iteration counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_a_raw    <= '0;
      r_mag_a    <= '0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_is_mul   <= 1'b0;
      r_div_zero <= 1'b0;
      r_div_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_cnt      <= WIDTH'(WIDTH - 1);
      r_a_raw    <= src_a;
      r_mag_a    <= w_mag_a;
      r_sa       <= w_op_signed && src_a[WIDTH-1];
      r_sb       <= w_op_signed && src_b[WIDTH-1];
      r_is_mul   <= w_op_mul;
      r_div_zero <= !w_op_mul && (src_b == '0);
      r_div_ovf  <= (mul_control == DivMc) && (src_a == MostNeg) && (src_b == '1);
    end else if ((r_state == StRun) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Multiplier
  // ---------------------------------------------------------------------------
  if (FAST_MUL != 0) begin : g_fast_mul
    logic [WIDTH-1:0] r_mag_b;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_mag_b <= '0;
      end else if (w_accept) begin
        r_mag_b <= w_mag_b;
      end
    end

    assign w_prod = {{WIDTH{1'b0}}, r_mag_a} * {{WIDTH{1'b0}}, r_mag_b};
  end else begin : g_iter_mul
    // {partial product, remaining multiplier bits}; shifts right once per step.
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH:0]     w_sum;

    assign w_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mag_a} : '0);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_prod <= '0;
      end else if (w_accept) begin
        r_prod <= {{WIDTH{1'b0}}, w_mag_b};
      end else if (w_step_mul) begin
        r_prod <= {w_sum, r_prod[WIDTH-1:1]};
      end
    end

    assign w_prod = r_prod;
  end

  // ---------------------------------------------------------------------------
  // Divider
  // ---------------------------------------------------------------------------
  muldiv_div_core #(
    .WIDTH (WIDTH)
  ) u_div_core (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept && !w_op_mul),
    .i_step     (w_step_div),
    .i_dividend (w_mag_a),
    .i_divisor  (w_mag_b),
    .o_quot     (w_quot),
    .o_rem      (w_rem)
  );

  // ---------------------------------------------------------------------------
  // Sign fix-up and special cases
  // ---------------------------------------------------------------------------
  always_comb begin
    w_prod_fix = (r_sa ^ r_sb) ? -w_prod : w_prod;
    w_quot_fix = (r_sa ^ r_sb) ? -w_quot : w_quot;
    w_rem_fix  = r_sa ? -w_rem : w_rem;
    if (r_is_mul) begin
      w_res_hi = w_prod_fix[2*WIDTH-1:WIDTH];
      w_res_lo = w_prod_fix[WIDTH-1:0];
    end else if (r_div_zero) begin
      w_res_hi = r_a_raw;
      w_res_lo = '1;
    end else if (r_div_ovf) begin
      w_res_hi = '0;
      w_res_lo = MostNeg;
    end else begin
      w_res_hi = w_rem_fix;
      w_res_lo = w_quot_fix;
    end
  end

  // ---------------------------------------------------------------------------
  // HI/LO: a completing op overrides a same-edge mthi/mtlo
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_fix_write;
      if (w_fix_write) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else begin
        if (hi_we) begin
          r_hi <= wdata;
        end
        if (lo_we) begin
          r_lo <= wdata;
        end
      end
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign done = r_done;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned IterLat = W + 1;  // ticks from accept edge to done visible

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start_valid;
  logic         f_start_valid;
  logic         start_ready;
  logic         f_start_ready;
  logic [3:0]   mul_control;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         cancel;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] f_hi;
  logic [W-1:0] f_lo;
  logic         busy;
  logic         f_busy;
  logic         done;
  logic         f_done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2*W-1:0] exp_q[$];

  muldiv_unit #(
    .WIDTH    (W),
    .FAST_MUL (0)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .mul_control (mul_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .cancel      (cancel),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .hi          (hi),
    .lo          (lo),
    .busy        (busy),
    .done        (done)
  );

  muldiv_unit #(
    .WIDTH    (W),
    .FAST_MUL (1)
  ) u_dut_fast (
    .clk         (clk),
    .rst         (rst),
    .start_valid (f_start_valid),
    .start_ready (f_start_ready),
    .mul_control (mul_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .cancel      (cancel),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .hi          (f_hi),
    .lo          (f_lo),
    .busy        (f_busy),
    .done        (f_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a legal op for one cycle and record its expected {hi, lo}.
  task automatic start_op(input logic [3:0] mc, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el);
    mul_control = mc;
    src_a       = a;
    src_b       = b;
    start_valid = 1'b1;
    exp_q.push_back({eh, el});
    tick();
    start_valid = 1'b0;
  endtask

  // Wait (bounded) for done, check latency, then pop and compare HI/LO.
  task automatic wait_done(input string tag, input int exp_lat);
    int k;
    logic [2*W-1:0] e;
    k = 0;
    while (done !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    check({tag, " latency"}, W'(k), W'(exp_lat));
    n_tests++;
    assert (exp_q.size() != 0)
    else begin
      n_fail++;
      $error("FAIL %s scoreboard: observed empty queue expected one entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, " hi"}, hi, e[2*W-1:W]);
      check({tag, " lo"}, lo, e[W-1:0]);
    end
  endtask

  initial begin
    int k;
    int n_done;

    rst           = 1'b1;
    start_valid   = 1'b0;
    f_start_valid = 1'b0;
    mul_control   = 4'b0000;
    src_a         = '0;
    src_b         = '0;
    cancel        = 1'b0;
    hi_we         = 1'b0;
    lo_we         = 1'b0;
    wdata         = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    check("reset busy", {31'b0, busy}, 32'h0);
    check("reset done", {31'b0, done}, 32'h0);
    check("reset start_ready", {31'b0, start_ready}, 32'h1);

    // multu max * max
    start_op(MultuMc, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    check("multu busy", {31'b0, busy}, 32'h1);
    check("multu start_ready", {31'b0, start_ready}, 32'h0);
    wait_done("multu max", IterLat);
    tick();
    check("multu done single pulse", {31'b0, done}, 32'h0);

    // Signed multiply and divide cases
    start_op(MultMc, -32'sd3, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    wait_done("mult -3*7", IterLat);
    tick();
    start_op(DivMc, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    wait_done("div -7/2", IterLat);
    tick();
    start_op(DivuMc, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF);
    wait_done("divu 7/0", IterLat);
    tick();
    start_op(DivMc, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    wait_done("div ovf", IterLat);
    tick();
    start_op(DivMc, 32'd7, -32'sd2, 32'd1, 32'hFFFF_FFFD);
    wait_done("div 7/-2", IterLat);
    tick();

    // Cancel a divu at cycle 10: HI/LO keep 1 / 0xFFFFFFFD, no done.
    mul_control = DivuMc;
    src_a       = 32'd100;
    src_b       = 32'd3;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel busy", {31'b0, busy}, 32'h0);
    check("cancel hi kept", hi, 32'd1);
    check("cancel lo kept", lo, 32'hFFFF_FFFD);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) n_done++;
      tick();
    end
    check("cancel no done", W'(n_done), 32'h0);
    hi_we = 1'b1;
    wdata = 32'h1234;
    tick();
    hi_we = 1'b0;
    check("mthi after cancel", hi, 32'h1234);

    // Reset in the middle of a multu
    mul_control = MultuMc;
    src_a       = 32'd5;
    src_b       = 32'd5;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midop reset hi", hi, 32'h0);
    check("midop reset lo", lo, 32'h0);
    check("midop reset start_ready", {31'b0, start_ready}, 32'h1);

    // Illegal (two-hot) control is ignored
    mul_control = 4'b0011;
    src_a       = 32'd9;
    src_b       = 32'd9;
    start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    check("illegal mc busy", {31'b0, busy}, 32'h0);
    tick();
    check("illegal mc still idle", {31'b0, busy}, 32'h0);

    // mtlo during RUN, then FIX overwrites
    start_op(MultuMc, 32'd2, 32'd3, 32'd0, 32'd6);
    tick();
    tick();
    tick();
    lo_we = 1'b1;
    wdata = 32'hAA;
    tick();
    lo_we = 1'b0;
    check("mtlo during run lo", lo, 32'hAA);
    check("mtlo during run hi", hi, 32'h0);
    wait_done("multu 2*3", IterLat - 4);

    // Back-to-back: start accepted in the done cycle
    check("ready while done", {31'b0, start_ready}, 32'h1);
    start_op(DivuMc, 32'd100, 32'd7, 32'd2, 32'd14);
    check("b2b busy", {31'b0, busy}, 32'h1);
    wait_done("divu 100/7", IterLat);
    tick();
    check("b2b done single pulse", {31'b0, done}, 32'h0);

    // FAST_MUL instance: done one tick after the accept edge
    mul_control   = MultMc;
    src_a         = -32'sd3;
    src_b         = 32'd7;
    f_start_valid = 1'b1;
    tick();
    f_start_valid = 1'b0;
    check("fast busy", {31'b0, f_busy}, 32'h1);
    k = 0;
    while (f_done !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    check("fast latency", W'(k), 32'd1);
    check("fast mult hi", f_hi, 32'hFFFF_FFFF);
    check("fast mult lo", f_lo, 32'hFFFF_FFEB);
    tick();
    check("fast done single pulse", {31'b0, f_done}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit that executes the multiply/divide control codes produced by the R-type ALU control decoder (mult, multu, div, divu) and owns the architectural HI/LO registers. It sits beside the ALU in EX and is parametrised in operand width and multiply speed. A busy/ready handshake lets the pipeline stall mfhi/mflo and back-to-back mult/div until the result lands.

## Interface
Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- FAST_MUL, 0: 0 selects an iterative shift-add multiply; 1 selects a single-cycle multiply. Divide is always iterative.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start_valid  in  1  request to start an operation.
- start_ready  out  1  unit can accept; equals ~busy.
- mul_control  in  4  one-hot op code; define.v fixes mult_mc=4'b0001, multu_mc=4'b0010, div_mc=4'b0100, divu_mc=4'b1000.
- src_a  in  WIDTH  rs operand (multiplicand/dividend).
- src_b  in  WIDTH  rt operand (multiplier/divisor).
- cancel  in  1  abort the in-flight operation (exception/flush).
- hi_we, lo_we  in  1  mthi/mtlo write enables.
- wdata  in  WIDTH  mthi/mtlo data.
- hi, lo  out  WIDTH  architectural HI/LO.
- busy  out  1  an operation is in flight.
- done  out  1  one-cycle pulse in the cycle after HI/LO take a result.

## Operation
- States: IDLE, RUN, FIX.
- IDLE: on start_valid & start_ready with a legal one-hot mul_control, latch operands and op, then go to RUN (or to FIX when FAST_MUL=1 and op is multiply). Zero or multiple bits in mul_control: request ignored, stay IDLE, no flag.
- Signed ops (mult, div): operands converted to magnitudes at accept; sign flags stored.
- RUN: one bit per cycle; a WIDTH-bit counter counts down from WIDTH-1; at 0 go to FIX.
  - Multiply: shift-add producing a 2·WIDTH-bit product.
  - Divide: restoring, producing WIDTH-bit quotient and remainder.
- FIX: apply signs (product sign = sa^sb; quotient sign = sa^sb; remainder sign = sa). Write HI = product[2W-1:W] / remainder, LO = product[W-1:0] / quotient. Return to IDLE.
- Divide by zero: HI = src_a, LO = all ones; same latency.
- Signed overflow (most-negative / -1): LO = most-negative, HI = 0.
- mthi/mtlo: applied on the same edge in any state. A pending result overwrites both registers in FIX. If hi_we and a FIX write hit the same edge, FIX wins.
- cancel: from RUN or FIX, go to IDLE on the next edge; HI/LO unchanged; no done. Ignored in IDLE. A start presented with cancel in IDLE is still accepted.
- Reset (also mid-operation): state IDLE, hi=0, lo=0, busy=0, done=0, counter=0.

## Timing
- Accept at edge T0; busy=1 from T0 until the FIX edge.
- Iterative ops: FIX edge at T0+WIDTH+1 updates HI/LO; done=1 during the following cycle. Total WIDTH+2 cycles, which is 34 for WIDTH=32.
- FAST_MUL multiply: FIX edge at T0+1; done in the next cycle.
- start_ready is low exactly while busy; a new start is accepted in the same cycle done is high.
- mthi/mtlo writes are visible on hi/lo one cycle after the write.

## Structure
- define.v holds mult_mc, multu_mc, div_mc, divu_mc and the state encodings.
- The divider datapath (remainder/quotient shift register plus subtractor) is a natural sub-module, muldiv_div_core. The multiplier stays inline, selected with a generate block on FAST_MUL.

## Test plan
- multu with a=0xFFFFFFFF, b=0xFFFFFFFF → after 34 cycles hi=0xFFFFFFFE, lo=0x00000001; done pulses once.
- mult with a=-3, b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. With FAST_MUL=1, done arrives 2 cycles after accept.
- div with a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu with a=7, b=0 → hi=7, lo=0xFFFFFFFF.
- Start a divu, assert cancel at cycle 10 → busy drops next cycle, hi/lo keep their prior values, no done. Then mthi 0x1234 → hi=0x1234.
- Start multu, assert rst at cycle 5 → hi=lo=0, start_ready=1. Next, mul_control=4'b0011 with start_valid → no operation, busy stays 0.
- mtlo 0xAA during RUN of multu 2×3 → lo=0xAA the next cycle, then lo=6, hi=0 at FIX.
